// File: rtl/dsel_pipe.sv
// dsel_pipe: registered N-way data selector with direct and round-robin
// selection, a one-stage valid/ready output register and a saturating
// error counter for invalid or disabled selections.
module dsel_pipe #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = $clog2(N),
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic [N-1:0]    ch_en,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   err_cnt,
    input  logic            clr_err
);

    localparam logic [CW-1:0] ERR_MAX = '1;

    logic          accept;
    logic [SW-1:0] rr_ptr;
    logic          dir_en;
    logic          hi_hit;
    logic          lo_hit;
    logic [SW-1:0] hi_k;
    logic [SW-1:0] lo_k;
    logic [W-1:0]  nxt_data;
    logic [SW-1:0] nxt_ch;
    logic          nxt_err;
    logic [SW-1:0] nxt_ptr;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Work out which channel this request would capture: direct lookup, or
    // the first enabled channel at/after rr_ptr (else the lowest enabled one,
    // which is the wrapped continuation of the search), then mux its data.
    always_comb begin
        dir_en   = 1'b0;
        hi_hit   = 1'b0;
        lo_hit   = 1'b0;
        hi_k     = '0;
        lo_k     = '0;
        nxt_ch   = '0;
        nxt_err  = 1'b0;
        nxt_ptr  = rr_ptr;
        nxt_data = '0;

        for (int k = N - 1; k >= 0; k--) begin
            if (sel == SW'(k)) begin
                dir_en = ch_en[k];
            end
            if (ch_en[k]) begin
                lo_hit = 1'b1;
                lo_k   = SW'(k);
            end
            if (ch_en[k] && (SW'(k) >= rr_ptr)) begin
                hi_hit = 1'b1;
                hi_k   = SW'(k);
            end
        end

        if (!mode) begin
            nxt_ch  = sel;
            nxt_err = !dir_en;
        end else if (hi_hit) begin
            nxt_ch = hi_k;
        end else if (lo_hit) begin
            nxt_ch = lo_k;
        end else begin
            nxt_ch  = rr_ptr;
            nxt_err = 1'b1;
        end

        if (mode && !nxt_err) begin
            nxt_ptr = (nxt_ch == SW'(N - 1)) ? '0 : nxt_ch + SW'(1);
        end

        if (!nxt_err) begin
            for (int k = 0; k < N; k++) begin
                if (nxt_ch == SW'(k)) begin
                    nxt_data = in_data[k*W +: W];
                end
            end
        end
    end

    // Output register and round-robin pointer: load on accept, drop valid
    // when the held transfer drains with nothing new behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_err   <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= nxt_data;
            out_ch    <= nxt_ch;
            out_err   <= nxt_err;
            rr_ptr    <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted error transfers; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (accept && nxt_err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_dsel_pipe.sv
// tb_dsel_pipe: scoreboard bench for dsel_pipe built as W=8, N=5 so that
// out-of-range selects and round-robin wrap are reachable.
module tb_dsel_pipe;

    localparam int W       = 8;
    localparam int N       = 5;
    localparam int SW      = $clog2(N);
    localparam int CW      = 8;
    localparam int DW      = N * W;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [SW-1:0] sel;
    logic          mode;
    logic [N-1:0]  ch_en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] err_cnt;
    logic          clr_err;

    typedef struct {
        int data;
        int ch;
        int err;
    } xfer_t;

    xfer_t q[$];
    int checks = 0;
    int errors = 0;
    int m_valid = 0;
    int m_rr = 0;
    int m_err = 0;

    dsel_pipe #(.W(W), .N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode),
        .ch_en(ch_en), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference selection straight from the selector rules.
    function automatic xfer_t refSelect(input logic [DW-1:0] d, input int s, input logic m,
                                        input logic [N-1:0] en, input int ptr,
                                        output int new_ptr);
        xfer_t x;
        int    found;
        int    k;
        new_ptr = ptr;
        x.data  = 0;
        x.err   = 1;
        if (!m) begin
            x.ch = s;
            if (s < N && ((int'(en) >> s) & 1) == 1) begin
                x.err  = 0;
                x.data = int'(W'(d >> (s * W)));
            end
        end else begin
            x.ch  = ptr;
            found = 0;
            for (int i = 0; i < N; i++) begin
                k = (ptr + i) % N;
                if (found == 0 && ((int'(en) >> k) & 1) == 1) begin
                    found   = 1;
                    x.ch    = k;
                    x.err   = 0;
                    x.data  = int'(W'(d >> (k * W)));
                    new_ptr = (k + 1) % N;
                end
            end
        end
        return x;
    endfunction

    function automatic logic [DW-1:0] randData();
        return DW'({$urandom(), $urandom()});
    endfunction

    // Drive one cycle of inputs, update the model, push any accepted
    // transfer, then check handshake state and the error counter.
    task automatic applyStimulus(input logic v, input logic m, input int s,
                                 input logic [N-1:0] en, input logic ordy,
                                 input logic clr, input logic [DW-1:0] d);
        int    acc;
        int    np;
        int    err_next;
        int    valid_next;
        xfer_t x;
        in_valid  = v;
        mode      = m;
        sel       = SW'(s);
        ch_en     = en;
        out_ready = ordy;
        clr_err   = clr;
        in_data   = d;
        #1;
        checkOutput("in_ready", int'(in_ready), (m_valid == 0 || ordy) ? 1 : 0);
        acc      = (v && (m_valid == 0 || ordy)) ? 1 : 0;
        err_next = m_err;
        x.err    = 0;
        np       = m_rr;
        if (acc == 1) begin
            x = refSelect(d, s, m, en, m_rr, np);
            q.push_back(x);
            m_rr = np;
        end
        if (clr) err_next = 0;
        else if (acc == 1 && x.err == 1 && m_err < ERR_MAX) err_next = m_err + 1;
        valid_next = (acc == 1) ? 1 : (ordy ? 0 : m_valid);
        @(posedge clk);
        #1;
        m_err   = err_next;
        m_valid = valid_next;
        checkOutput("out_valid", int'(out_valid), m_valid);
        checkOutput("err_cnt", int'(err_cnt), m_err);
    endtask

    task automatic resetDut();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_ch", int'(out_ch), 0);
        checkOutput("rst_out_err", int'(out_err), 0);
        checkOutput("rst_err_cnt", int'(err_cnt), 0);
        q.delete();
        m_valid = 0;
        m_rr    = 0;
        m_err   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: whenever a transfer is consumed, compare it to the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got out_valid 1, expected no pending transfer at %0t", $time);
            end else begin
                xfer_t e;
                e = q.pop_front();
                checkOutput("out_data", int'(out_data), e.data);
                checkOutput("out_ch", int'(out_ch), e.ch);
                checkOutput("out_err", int'(out_err), e.err);
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [W-1:0]  held_data;
        logic [SW-1:0] held_ch;
        int            exp_rr[4];

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        ch_en     = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        in_data   = '0;
        @(posedge clk);
        #1;
        resetDut();
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Direct select, back-to-back over every channel.
        d = {8'h44, 8'h33, 8'h22, 8'h11, 8'hA5};
        for (int s = 0; s < N; s++) applyStimulus(1, 0, s, '1, 1, 0, d);

        // Backpressure: hold for five cycles, then drain and accept together.
        applyStimulus(1, 0, 1, '1, 1, 0, d);
        held_data = out_data;
        held_ch   = out_ch;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 3, '1, 0, 0, d);
            checkOutput("stall_data", int'(out_data), int'(held_data));
            checkOutput("stall_ch", int'(out_ch), int'(held_ch));
        end
        applyStimulus(1, 0, 3, '1, 1, 0, d);
        checkOutput("drain_accept_ch", int'(out_ch), 3);

        // Round-robin from reset over a sparse mask, then an empty mask.
        resetDut();
        exp_rr = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 5'b01010, 1, 0, d);
            checkOutput("rr_ch", int'(out_ch), exp_rr[i]);
        end
        applyStimulus(1, 1, 0, 5'b00000, 1, 0, d);
        checkOutput("rr_empty_err", int'(out_err), 1);
        checkOutput("rr_empty_data", int'(out_data), 0);
        checkOutput("rr_empty_ch", int'(out_ch), 4);
        checkOutput("rr_empty_cnt", int'(err_cnt), 1);

        // Disabled channel repeatedly: counter saturates, then clear beats increment.
        for (int i = 0; i < 300; i++) applyStimulus(1, 0, 2, 5'b11011, 1, 0, randData());
        checkOutput("err_cnt_sat", int'(err_cnt), ERR_MAX);
        checkOutput("dis_ch", int'(out_ch), 2);
        applyStimulus(1, 0, 2, 5'b11011, 1, 1, d);
        checkOutput("err_cnt_clr", int'(err_cnt), 0);

        // Out-of-range selects and the top channel.
        for (int s = 5; s < 8; s++) begin
            applyStimulus(1, 0, s, '1, 1, 0, d);
            checkOutput("oor_err", int'(out_err), 1);
            checkOutput("oor_ch", int'(out_ch), s);
        end
        applyStimulus(1, 0, 4, '1, 1, 0, d);
        checkOutput("sel4_data", int'(out_data), int'(d[4*W +: W]));

        // Round-robin wrap: park the pointer at 4, then only channel 0 enabled.
        applyStimulus(1, 1, 0, 5'b01000, 1, 0, d);
        checkOutput("rr_park_ch", int'(out_ch), 3);
        applyStimulus(1, 1, 0, 5'b00001, 1, 0, d);
        checkOutput("rr_wrap_ch", int'(out_ch), 0);

        // Asynchronous reset while a transfer is held under backpressure.
        applyStimulus(1, 0, 1, '1, 1, 0, d);
        applyStimulus(0, 0, 0, '1, 0, 0, d);
        resetDut();
        applyStimulus(1, 1, 0, '1, 1, 0, d);
        checkOutput("post_reset_rr_ch", int'(out_ch), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] en;
            en = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom());
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7), en, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 49) == 0, randData());
        end

        repeat (3) applyStimulus(0, 0, 0, '1, 1, 0, '0);
        checkOutput("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
